st4_mem: RTL and testbench
==========================

# st4_mem

Memory-access stage of the multi-cycle CPU, between execute and write-back. Captures the execute→memory bus on a start pulse and drives a request/ready data-memory port for loads and stores. Performs byte/halfword lane selection, sign/zero extension and store byte-enable generation. Presents a registered 70-bit memory→write-back bus to the write-back stage with a one-cycle completion pulse.

## Interface
- No parameters.
- `clk` input 1: stage clock.
- `rst` input 1: asynchronous reset, active-high.
- `MEM_valid` input 1: one-cycle start pulse from the top-level controller.
- `EXE_MEM_bus_r` input 107: `{is_load, is_store, sign_ext, size[1:0], store_data[31:0], exe_result[31:0], wen, wdest[4:0], pc[31:0]}`.
- `MEM_over` output 1: one-cycle completion pulse.
- `MEM_WB_bus` output 70: `{wen, wdest[4:0], mem_result[31:0], pc[31:0]}`. Registered; stable from `MEM_over` until the next completion.
- `mem_misalign` output 1: registered; set at completion of a misaligned access.
- `dm_en` output 1: data-memory request.
- `dm_wen` output 4: byte write enables; nonzero only for stores.
- `dm_addr` output 32: `{exe_result[31:2], 2'b00}`.
- `dm_wdata` output 32: lane-replicated store data.
- `dm_rdata` input 32: read word; valid in the cycle `dm_ready`=1.
- `dm_ready` input 1: memory completion, sampled only while `dm_en`=1.
- `MEM_pc` output 32: pc of the captured instruction, for display.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - On `MEM_valid`=1, capture `EXE_MEM_bus_r` into an internal register.
  - Go to ACCESS if `(is_load|is_store)` and the access is aligned; otherwise go to DONE.
  - `MEM_valid` is ignored in ACCESS and DONE.
- **ACCESS:**
  - `dm_en`=1 and address, `wen` and data are held constant.
  - On `dm_ready`=1, latch `dm_rdata` and go to DONE.
  - There is no timeout; `dm_ready` may take any number of cycles.
- **DONE:**
  - `MEM_over`=1 for exactly one cycle.
  - `MEM_WB_bus` and `mem_misalign` update at the clock edge that leaves DONE.
  - DONE always returns to IDLE.
- **Size field:**
  - `00`: byte.
  - `01`: halfword.
  - `10` and `11`: word.
- **Misaligned access:**
  - Defined as halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - No memory request is issued.
  - `mem_misalign`=1.
  - `wen` in `MEM_WB_bus` is forced to 0.
  - `mem_result`=0.
- **Loads:**
  - Byte: lane = `addr[1:0]`, i.e. `rdata[8*a+7:8*a]`.
  - Halfword: `rdata[16*addr[1]+15 -: 16]`.
  - Extend to 32 bits: sign extension when `sign_ext`=1, zero extension otherwise.
- **Stores:**
  - Byte: `dm_wen` = `4'b0001 << addr[1:0]`; `dm_wdata` = `{4{sd[7:0]}}`.
  - Halfword: `dm_wen` = `4'b0011 << {addr[1],1'b0}`; `dm_wdata` = `{2{sd[15:0]}}`.
  - Word: `dm_wen`=`4'hF`; `dm_wdata`=`sd`.
  - `mem_result` = `exe_result`.
- **Non-memory ops:** `mem_result` = `exe_result`.
- **Pass-through:** `wen`, `wdest` and `pc` pass through unchanged, except for the misalignment override on `wen`.
- **Priority:** if `is_load` and `is_store` are both 1, the op is treated as a load.

## Timing
- **Reset values:** `rst` forces the state to IDLE and every output to 0 immediately, asynchronously, including `dm_en`, `MEM_WB_bus` and `MEM_pc`.
- **Reset mid-ACCESS:** `dm_en` drops at once; the pending `dm_ready` is ignored after release.
- **Cycle numbering:** cycle 0 is the cycle in which `MEM_valid`=1.
- **Non-memory or misaligned op:** `MEM_over`=1 in cycle 1.
- **Memory op:**
  - `dm_en` is first asserted in cycle 1.
  - If `dm_ready`=1 in cycle k (k≥1), `MEM_over`=1 in cycle k+1.
  - Minimum latency is 2 cycles.
- **Bus timing:** `MEM_WB_bus` holds its previous value through `MEM_over` and shows new data from cycle k+2. The write-back stage consumes it through its own input register.
- **Display pc:** `MEM_pc` is valid from cycle 1 until the next capture.
- **No accepted instructions while busy:** a `MEM_valid` arriving in ACCESS or DONE is dropped. A new instruction is accepted in the cycle immediately after DONE.

## Test plan
- **ALU op:** bus with `is_load`=`is_store`=0, `exe_result`=`32'h1234_5678`, `wen`=1, `wdest`=5, `pc`=`32'h0000_0040` → `MEM_over` in cycle 1; `MEM_WB_bus` = `{1,5'd5,32'h12345678,32'h40}`; `dm_en` never asserted.
- **Signed byte load:** addr `32'h0000_0103`, `dm_rdata`=`32'h80FF_0000`, `dm_ready` in cycle 3 → `dm_addr`=`32'h100`, `MEM_over` in cycle 4, `mem_result`=`32'hFFFF_FF80`. With `sign_ext`=0 → `32'h0000_0080`.
- **Halfword store:** addr `32'h22`, `sd`=`32'hAAAA_BEEF` → while `dm_en`=1: `dm_wen`=`4'b1100`, `dm_wdata`=`32'hBEEF_BEEF`, `dm_addr`=`32'h20`.
- **Misaligned word load:** addr `32'h0000_0006` → no `dm_en`; `MEM_over` in cycle 1; `mem_misalign`=1; bus `wen`=0; `mem_result`=0.
- **Back-to-back with ignored pulse:** a second `MEM_valid` during ACCESS is ignored; a third pulse issued the cycle after DONE completes normally.
- **Reset mid-access:** assert `rst` in cycle 2 of a word load with `dm_ready` held 0 → `dm_en`, `MEM_over` and `MEM_WB_bus` are 0 immediately; after release, a new ALU op completes in 1 cycle.

Source files
------------

// File: rtl/st4_mem.sv
// st4_mem -- memory-access stage of the multi-cycle CPU.
//
// The stage captures the execute->memory bus on a start pulse. It runs one
// load or store over a request/ready data-memory port. It then presents a
// registered memory->write-back bus together with a one-cycle completion
// pulse.
//
// Ports
//   clk, rst       stage clock; asynchronous active-high reset
//   MEM_valid      one-cycle start pulse (ignored while busy)
//   EXE_MEM_bus_r  {is_load, is_store, sign_ext, size[1:0], store_data[31:0],
//                   exe_result[31:0], wen, wdest[4:0], pc[31:0]}
//   MEM_over       one-cycle completion pulse
//   MEM_WB_bus     {wen, wdest[4:0], mem_result[31:0], pc[31:0]}, registered
//   mem_misalign   registered, set when the last completed access was misaligned
//   dm_en          data-memory request
//   dm_wen         byte write enables (stores only)
//   dm_addr        word-aligned access address
//   dm_wdata       lane-replicated store data
//   dm_rdata       read word, valid while dm_ready=1
//   dm_ready       memory completion, sampled only while dm_en=1
//   MEM_pc         pc of the captured instruction
module st4_mem (
  input  logic         clk,
  input  logic         rst,
  input  logic         MEM_valid,
  input  logic [106:0] EXE_MEM_bus_r,
  output logic         MEM_over,
  output logic [69:0]  MEM_WB_bus,
  output logic         mem_misalign,
  output logic         dm_en,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_addr,
  output logic [31:0]  dm_wdata,
  input  logic [31:0]  dm_rdata,
  input  logic         dm_ready,
  output logic [31:0]  MEM_pc
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t       state;
  logic [106:0] bus_q;
  logic [31:0]  rdata_q;
  logic         mis_q;

  // Fields of the incoming bus, used only to decide the first transition.
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_size;
  logic [1:0]  in_alo;
  logic        in_mem;
  logic        in_mis;

  assign in_load  = EXE_MEM_bus_r[106];
  assign in_store = EXE_MEM_bus_r[105];
  assign in_size  = EXE_MEM_bus_r[103:102];
  assign in_alo   = EXE_MEM_bus_r[39:38];
  assign in_mem   = in_load | in_store;
  assign in_mis   = in_mem &
                    (((in_size == 2'b01) && in_alo[0]) ||
                     (in_size[1] && (in_alo != 2'b00)));

  // Fields of the captured bus.
  logic        q_load;
  logic        q_store;
  logic        q_sext;
  logic [1:0]  q_size;
  logic [31:0] q_sd;
  logic [31:0] q_exe;
  logic        q_wen;
  logic [4:0]  q_wdest;
  logic [31:0] q_pc;

  assign q_load  = bus_q[106];
  assign q_store = bus_q[105];
  assign q_sext  = bus_q[104];
  assign q_size  = bus_q[103:102];
  assign q_sd    = bus_q[101:70];
  assign q_exe   = bus_q[69:38];
  assign q_wen   = bus_q[37];
  assign q_wdest = bus_q[36:32];
  assign q_pc    = bus_q[31:0];

  // Load lane selection and extension from the latched read word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] mem_result;

  always_comb begin
    ld_byte = rdata_q[7:0];
    unique case (q_exe[1:0])
      2'd0: ld_byte = rdata_q[7:0];
      2'd1: ld_byte = rdata_q[15:8];
      2'd2: ld_byte = rdata_q[23:16];
      2'd3: ld_byte = rdata_q[31:24];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = q_exe[1] ? rdata_q[31:16] : rdata_q[15:0];

    if (q_size == 2'b00)
      ld_value = {{24{q_sext & ld_byte[7]}}, ld_byte};
    else if (q_size == 2'b01)
      ld_value = {{16{q_sext & ld_half[15]}}, ld_half};
    else
      ld_value = rdata_q;

    // A load wins over a store when both flags are set.
    if (mis_q)
      mem_result = '0;
    else if (q_load)
      mem_result = ld_value;
    else
      mem_result = q_exe;
  end

  // Store lane enables and data replication.
  logic [3:0]  st_wen;
  logic [31:0] st_wdata;

  always_comb begin
    if (q_size == 2'b00) begin
      st_wen   = 4'b0001 << q_exe[1:0];
      st_wdata = {4{q_sd[7:0]}};
    end else if (q_size == 2'b01) begin
      st_wen   = 4'b0011 << {q_exe[1], 1'b0};
      st_wdata = {2{q_sd[15:0]}};
    end else begin
      st_wen   = 4'hF;
      st_wdata = q_sd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus_q        <= '0;
      rdata_q      <= '0;
      mis_q        <= 1'b0;
      MEM_WB_bus   <= '0;
      mem_misalign <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (MEM_valid) begin
            bus_q <= EXE_MEM_bus_r;
            mis_q <= in_mis;
            state <= (in_mem && !in_mis) ? ACCESS : DONE;
          end
        end
        ACCESS: begin
          if (dm_ready) begin
            rdata_q <= dm_rdata;
            state   <= DONE;
          end
        end
        DONE: begin
          MEM_WB_bus   <= {q_wen & ~mis_q, q_wdest, mem_result, q_pc};
          mem_misalign <= mis_q;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // These outputs decode directly from reset-cleared registers, so reset
  // clears them at once.
  assign MEM_over = (state == DONE);
  assign dm_en    = (state == ACCESS);
  assign dm_addr  = {q_exe[31:2], 2'b00};
  assign dm_wen   = (dm_en && q_store && !q_load) ? st_wen : 4'b0000;
  assign dm_wdata = st_wdata;
  assign MEM_pc   = q_pc;

endmodule

// File: tb/tb_st4_mem.sv
module tb_st4_mem;

  logic         clk;
  logic         rst;
  logic         MEM_valid;
  logic [106:0] EXE_MEM_bus_r;
  logic         MEM_over;
  logic [69:0]  MEM_WB_bus;
  logic         mem_misalign;
  logic         dm_en;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic [31:0]  dm_rdata;
  logic         dm_ready;
  logic [31:0]  MEM_pc;

  int n_checks = 0;
  int n_fails  = 0;

  st4_mem dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_valid     (MEM_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .MEM_over      (MEM_over),
    .MEM_WB_bus    (MEM_WB_bus),
    .mem_misalign  (mem_misalign),
    .dm_en         (dm_en),
    .dm_wen        (dm_wen),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_ready      (dm_ready),
    .MEM_pc        (MEM_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [106:0] mk(input logic ld, input logic st, input logic sx,
                                      input logic [1:0] size, input logic [31:0] sd,
                                      input logic [31:0] exe, input logic wen,
                                      input logic [4:0] wdest, input logic [31:0] pc);
    return {ld, st, sx, size, sd, exe, wen, wdest, pc};
  endfunction

  function automatic logic [69:0] wb(input logic wen, input logic [4:0] wdest,
                                     input logic [31:0] res, input logic [31:0] pc);
    return {wen, wdest, res, pc};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start pulse in the current cycle; returns in cycle 1.
  task automatic issue(input logic [106:0] bus);
    MEM_valid     = 1'b1;
    EXE_MEM_bus_r = bus;
    step();
    MEM_valid     = 1'b0;
    EXE_MEM_bus_r = '0;
  endtask

  initial begin
    rst           = 1'b1;
    MEM_valid     = 1'b0;
    EXE_MEM_bus_r = '0;
    dm_rdata      = '0;
    dm_ready      = 1'b0;
    #1;
    check("rst_over",  MEM_over, 0);
    check("rst_dm_en", dm_en, 0);
    check("rst_wb",    MEM_WB_bus, 0);
    check("rst_pc",    MEM_pc, 0);
    check("rst_mis",   mem_misalign, 0);
    check("rst_wen",   dm_wen, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // ALU op
    issue(mk(0, 0, 0, 2'b10, 32'h0, 32'h1234_5678, 1, 5'd5, 32'h40));
    check("alu_over_c1", MEM_over, 1);
    check("alu_dm_en",   dm_en, 0);
    check("alu_pc",      MEM_pc, 32'h40);
    check("alu_wb_hold", MEM_WB_bus, 0);
    step();
    check("alu_over_c2", MEM_over, 0);
    check("alu_wb",      MEM_WB_bus, wb(1, 5'd5, 32'h1234_5678, 32'h40));
    check("alu_mis",     mem_misalign, 0);

    // Signed byte load, lane 3, ready in cycle 3
    issue(mk(1, 0, 1, 2'b00, 32'h0, 32'h0000_0103, 1, 5'd7, 32'h80));
    check("lb_dm_en_c1", dm_en, 1);
    check("lb_addr",     dm_addr, 32'h100);
    check("lb_wen",      dm_wen, 0);
    step();
    check("lb_dm_en_c2", dm_en, 1);
    check("lb_over_c2",  MEM_over, 0);
    step();
    dm_ready = 1'b1;
    dm_rdata = 32'h80FF_0000;
    step();
    dm_ready = 1'b0;
    dm_rdata = '0;
    check("lb_over_c4",  MEM_over, 1);
    check("lb_dm_en_c4", dm_en, 0);
    step();
    check("lb_wb", MEM_WB_bus, wb(1, 5'd7, 32'hFFFF_FF80, 32'h80));

    // Unsigned byte load, minimum latency
    issue(mk(1, 0, 0, 2'b00, 32'h0, 32'h0000_0103, 1, 5'd7, 32'h84));
    dm_ready = 1'b1;
    dm_rdata = 32'h80FF_0000;
    step();
    dm_ready = 1'b0;
    check("lbu_over_c2", MEM_over, 1);
    step();
    check("lbu_wb", MEM_WB_bus, wb(1, 5'd7, 32'h0000_0080, 32'h84));

    // Signed halfword load, upper half
    issue(mk(1, 0, 1, 2'b01, 32'h0, 32'h0000_0002, 1, 5'd8, 32'h88));
    dm_ready = 1'b1;
    dm_rdata = 32'h8001_1234;
    step();
    dm_ready = 1'b0;
    step();
    check("lh_wb", MEM_WB_bus, wb(1, 5'd8, 32'hFFFF_8001, 32'h88));

    // Halfword store at 0x22
    issue(mk(0, 1, 0, 2'b01, 32'hAAAA_BEEF, 32'h0000_0022, 0, 5'd0, 32'h100));
    check("sh_dm_en",  dm_en, 1);
    check("sh_wen",    dm_wen, 4'b1100);
    check("sh_wdata",  dm_wdata, 32'hBEEF_BEEF);
    check("sh_addr",   dm_addr, 32'h20);
    dm_ready = 1'b1;
    step();
    dm_ready = 1'b0;
    check("sh_over", MEM_over, 1);
    step();
    check("sh_wb", MEM_WB_bus, wb(0, 5'd0, 32'h0000_0022, 32'h100));

    // Byte store at lane 1
    issue(mk(0, 1, 0, 2'b00, 32'h3456_7812, 32'h0000_0031, 0, 5'd0, 32'h104));
    check("sb_wen",   dm_wen, 4'b0010);
    check("sb_wdata", dm_wdata, 32'h1212_1212);
    check("sb_addr",  dm_addr, 32'h30);
    dm_ready = 1'b1;
    step();
    dm_ready = 1'b0;
    step();

    // Word store
    issue(mk(0, 1, 0, 2'b11, 32'hCAFE_0001, 32'h0000_0044, 0, 5'd0, 32'h108));
    check("sw_wen",   dm_wen, 4'hF);
    check("sw_wdata", dm_wdata, 32'hCAFE_0001);
    dm_ready = 1'b1;
    step();
    dm_ready = 1'b0;
    step();

    // Load and store both set: treated as a word load
    issue(mk(1, 1, 0, 2'b10, 32'h5555_5555, 32'h0000_0008, 1, 5'd2, 32'h10C));
    check("ls_wen",   dm_wen, 0);
    check("ls_dm_en", dm_en, 1);
    dm_ready = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    step();
    dm_ready = 1'b0;
    step();
    check("ls_wb", MEM_WB_bus, wb(1, 5'd2, 32'hCAFE_F00D, 32'h10C));

    // Misaligned word load
    issue(mk(1, 0, 0, 2'b10, 32'h0, 32'h0000_0006, 1, 5'd3, 32'h44));
    check("mis_over",  MEM_over, 1);
    check("mis_dm_en", dm_en, 0);
    step();
    check("mis_wb",    MEM_WB_bus, wb(0, 5'd3, 32'h0, 32'h44));
    check("mis_flag",  mem_misalign, 1);

    // Back-to-back: pulses in ACCESS and DONE are dropped
    issue(mk(1, 0, 0, 2'b10, 32'h0, 32'h0000_0010, 1, 5'd1, 32'h50));
    MEM_valid     = 1'b1;
    EXE_MEM_bus_r = mk(0, 0, 0, 2'b10, 32'h0, 32'h0000_0BAD, 1, 5'd4, 32'h99);
    step();
    MEM_valid     = 1'b0;
    check("b2b_pc_c2",    MEM_pc, 32'h50);
    check("b2b_dm_en_c2", dm_en, 1);
    dm_ready = 1'b1;
    dm_rdata = 32'h1111_2222;
    step();
    dm_ready  = 1'b0;
    MEM_valid = 1'b1;
    check("b2b_over_c3", MEM_over, 1);
    step();
    MEM_valid = 1'b0;
    check("b2b_over_c4", MEM_over, 0);
    check("b2b_wb_a",    MEM_WB_bus, wb(1, 5'd1, 32'h1111_2222, 32'h50));
    check("b2b_pc_c4",   MEM_pc, 32'h50);
    check("b2b_mis_clr", mem_misalign, 0);
    issue(mk(0, 0, 0, 2'b10, 32'h0, 32'h0000_DEAD, 1, 5'd9, 32'h60));
    check("b2b_over_c",  MEM_over, 1);
    check("b2b_pc_c",    MEM_pc, 32'h60);
    step();
    check("b2b_wb_c",    MEM_WB_bus, wb(1, 5'd9, 32'h0000_DEAD, 32'h60));

    // Reset in cycle 2 of a word load that never gets ready
    issue(mk(1, 0, 0, 2'b10, 32'h0, 32'h0000_0200, 1, 5'd6, 32'h70));
    step();
    check("rma_dm_en_pre", dm_en, 1);
    rst = 1'b1;
    #1;
    check("rma_dm_en", dm_en, 0);
    check("rma_over",  MEM_over, 0);
    check("rma_wb",    MEM_WB_bus, 0);
    check("rma_pc",    MEM_pc, 0);
    step();
    rst      = 1'b0;
    dm_ready = 1'b1;
    step();
    dm_ready = 1'b0;
    check("rma_idle_dm_en", dm_en, 0);
    check("rma_idle_over",  MEM_over, 0);
    issue(mk(0, 0, 0, 2'b10, 32'h0, 32'h0000_0777, 1, 5'd10, 32'h74));
    check("rma_alu_over", MEM_over, 1);
    step();
    check("rma_alu_wb", MEM_WB_bus, wb(1, 5'd10, 32'h0000_0777, 32'h74));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
